// File: rtl/note_pkg.sv
// Shared widths, state encoding and constants for the note player slice.
package note_pkg;

    localparam int unsigned NOTE_W  = 6;
    localparam int unsigned DUR_W   = 6;
    localparam int unsigned PHASE_W = 22;
    localparam int unsigned STEP_W  = 20;
    localparam int unsigned ADDR_W  = 10;

    typedef enum logic {
        IDLE    = 1'b0,
        PLAYING = 1'b1
    } state_t;

    localparam logic [NOTE_W-1:0] REST_NOTE = '0;

endpackage

// File: rtl/frequency_rom.sv
// Pitch code to phase-step lookup, one registered cycle of latency.
// step = round(f * 2^22 / 48000), f = 440 * 2^((code-49)/12); code 0 is a rest.
// Ports: clk, reset (sync, active high), note (pitch code), step (phase increment).
module frequency_rom
    import note_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [NOTE_W-1:0] note,
    output logic [STEP_W-1:0] step
);

    // Combinational table; the register below supplies the latency.
    function automatic logic [STEP_W-1:0] lookup(input logic [NOTE_W-1:0] code);
        logic [STEP_W-1:0] s;
        case (code)
            6'd1:  s = 20'd2403;   6'd2:  s = 20'd2546;   6'd3:  s = 20'd2697;
            6'd4:  s = 20'd2858;   6'd5:  s = 20'd3028;   6'd6:  s = 20'd3208;
            6'd7:  s = 20'd3398;   6'd8:  s = 20'd3600;   6'd9:  s = 20'd3815;
            6'd10: s = 20'd4041;   6'd11: s = 20'd4282;   6'd12: s = 20'd4536;
            6'd13: s = 20'd4806;   6'd14: s = 20'd5092;   6'd15: s = 20'd5395;
            6'd16: s = 20'd5715;   6'd17: s = 20'd6055;   6'd18: s = 20'd6415;
            6'd19: s = 20'd6797;   6'd20: s = 20'd7201;   6'd21: s = 20'd7629;
            6'd22: s = 20'd8083;   6'd23: s = 20'd8563;   6'd24: s = 20'd9072;
            6'd25: s = 20'd9612;   6'd26: s = 20'd10184;  6'd27: s = 20'd10789;
            6'd28: s = 20'd11431;  6'd29: s = 20'd12110;  6'd30: s = 20'd12830;
            6'd31: s = 20'd13593;  6'd32: s = 20'd14402;  6'd33: s = 20'd15258;
            6'd34: s = 20'd16165;  6'd35: s = 20'd17127;  6'd36: s = 20'd18145;
            6'd37: s = 20'd19224;  6'd38: s = 20'd20367;  6'd39: s = 20'd21578;
            6'd40: s = 20'd22861;  6'd41: s = 20'd24221;  6'd42: s = 20'd25661;
            6'd43: s = 20'd27187;  6'd44: s = 20'd28803;  6'd45: s = 20'd30516;
            6'd46: s = 20'd32331;  6'd47: s = 20'd34253;  6'd48: s = 20'd36290;
            6'd49: s = 20'd38448;  6'd50: s = 20'd40734;  6'd51: s = 20'd43156;
            6'd52: s = 20'd45722;  6'd53: s = 20'd48441;  6'd54: s = 20'd51322;
            6'd55: s = 20'd54373;  6'd56: s = 20'd57607;  6'd57: s = 20'd61032;
            6'd58: s = 20'd64661;  6'd59: s = 20'd68506;  6'd60: s = 20'd72580;
            6'd61: s = 20'd76896;  6'd62: s = 20'd81468;  6'd63: s = 20'd86312;
            default: s = '0;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (reset || note == REST_NOTE) begin
            step <= '0;
        end else begin
            step <= lookup(note);
        end
    end

endmodule

// File: rtl/note_player.sv
// Holds one note for its duration in beats and runs a phase accumulator
// at the sample-strobe rate while the note sounds.
// Ports: clk, reset (sync, active high), play_enable (0 freezes everything),
//   note_to_load / duration_to_load / load_new_note (note capture),
//   beat, generate_next_sample (timing strobes),
//   done_with_note (pulse at end of note), note_active (in PLAYING),
//   sample_addr / new_sample_ready (sine-table address and its strobe).
module note_player
    import note_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              play_enable,
    input  logic [NOTE_W-1:0] note_to_load,
    input  logic [DUR_W-1:0]  duration_to_load,
    input  logic              load_new_note,
    input  logic              beat,
    input  logic              generate_next_sample,
    output logic              done_with_note,
    output logic              note_active,
    output logic [ADDR_W-1:0] sample_addr,
    output logic              new_sample_ready
);

    state_t              state;
    logic [NOTE_W-1:0]   note_reg;
    logic [DUR_W-1:0]    dur_count;
    logic [PHASE_W-1:0]  phase;
    logic [STEP_W-1:0]   step;
    logic [PHASE_W-1:0]  phase_next;

    frequency_rom u_rom (
        .clk   (clk),
        .reset (reset),
        .note  (note_reg),
        .step  (step)
    );

    // Wraps naturally modulo 2^PHASE_W.
    assign phase_next = phase + PHASE_W'(step);

    // Load beats everything else; counting only runs while playing and enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            note_reg         <= '0;
            dur_count        <= '0;
            phase            <= '0;
            done_with_note   <= 1'b0;
            note_active      <= 1'b0;
            sample_addr      <= '0;
            new_sample_ready <= 1'b0;
        end else begin
            done_with_note   <= 1'b0;
            new_sample_ready <= 1'b0;
            if (load_new_note) begin
                note_reg    <= note_to_load;
                dur_count   <= (duration_to_load == '0) ? DUR_W'(1) : duration_to_load;
                phase       <= '0;
                state       <= PLAYING;
                note_active <= 1'b1;
            end else if (state == PLAYING && play_enable) begin
                if (beat) begin
                    if (dur_count == DUR_W'(1)) begin
                        done_with_note <= 1'b1;
                        state          <= IDLE;
                        dur_count      <= '0;
                        note_active    <= 1'b0;
                    end else begin
                        dur_count <= dur_count - DUR_W'(1);
                    end
                end
                if (generate_next_sample) begin
                    phase            <= phase_next;
                    sample_addr      <= phase_next[PHASE_W-1 -: ADDR_W];
                    new_sample_ready <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player: a per-cycle vector table for reset and a
// short note, then hand-written sequences for the multi-cycle behaviours.
module tb_note_player;

    logic       clk = 1'b0;
    logic       reset;
    logic       play_enable;
    logic [5:0] note_to_load;
    logic [5:0] duration_to_load;
    logic       load_new_note;
    logic       beat;
    logic       generate_next_sample;
    logic       done_with_note;
    logic       note_active;
    logic [9:0] sample_addr;
    logic       new_sample_ready;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int nsr_cnt = 0;

    always #5 clk = ~clk;

    note_player dut (
        .clk                  (clk),
        .reset                (reset),
        .play_enable          (play_enable),
        .note_to_load         (note_to_load),
        .duration_to_load     (duration_to_load),
        .load_new_note        (load_new_note),
        .beat                 (beat),
        .generate_next_sample (generate_next_sample),
        .done_with_note       (done_with_note),
        .note_active          (note_active),
        .sample_addr          (sample_addr),
        .new_sample_ready     (new_sample_ready)
    );

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (done_with_note === 1'b1) done_cnt <= done_cnt + 1;
        if (new_sample_ready === 1'b1) nsr_cnt <= nsr_cnt + 1;
    end

    typedef struct {
        logic       rst, play, load, bt, gen;
        logic [5:0] note, dur;
        logic       e_done, e_active, e_nsr;
        logic [9:0] e_addr;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock; outputs of that edge are stable afterwards.
    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) clk1();
    endtask

    task automatic do_load(input logic [5:0] n, input logic [5:0] d);
        note_to_load = n; duration_to_load = d; load_new_note = 1'b1;
        clk1();
        load_new_note = 1'b0;
    endtask

    task automatic do_beat();
        beat = 1'b1;
        clk1();
        beat = 1'b0;
    endtask

    task automatic do_sample();
        generate_next_sample = 1'b1;
        clk1();
        generate_next_sample = 1'b0;
        clk1();
    endtask

    function automatic vec_t mk(input logic rst, input logic ld, input logic bt,
                                input logic gen, input logic e_done, input logic e_act,
                                input logic e_nsr, input logic [9:0] e_addr);
        vec_t v;
        v.rst = rst; v.play = 1'b1; v.load = ld; v.bt = bt; v.gen = gen;
        v.note = 6'd49; v.dur = 6'd3;
        v.e_done = e_done; v.e_active = e_act; v.e_nsr = e_nsr; v.e_addr = e_addr;
        return v;
    endfunction

    initial begin
        int base_done;
        int base_nsr;
        logic [21:0] exp_phase;
        logic [9:0] held_addr;

        // rst  ld   bt   gen   done act  nsr  addr
        vecs[0]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        vecs[1]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
        vecs[2]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
        vecs[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
        vecs[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
        vecs[5]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 10'd9);
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd9);
        vecs[8]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd9);
        vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 10'd18);
        vecs[10] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd18);
        vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd18);
        vecs[12] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd18);

        reset = 1'b1; play_enable = 1'b1; note_to_load = '0; duration_to_load = '0;
        load_new_note = 1'b0; beat = 1'b0; generate_next_sample = 1'b0;
        #2;

        // Table: reset with load held, then a 3-beat note with two samples.
        for (int i = 0; i < 13; i++) begin
            reset = vecs[i].rst; play_enable = vecs[i].play; load_new_note = vecs[i].load;
            beat = vecs[i].bt; generate_next_sample = vecs[i].gen;
            note_to_load = vecs[i].note; duration_to_load = vecs[i].dur;
            clk1();
            check($sformatf("vec%0d done", i), int'(done_with_note), int'(vecs[i].e_done));
            check($sformatf("vec%0d active", i), int'(note_active), int'(vecs[i].e_active));
            check($sformatf("vec%0d nsr", i), int'(new_sample_ready), int'(vecs[i].e_nsr));
            check($sformatf("vec%0d addr", i), int'(sample_addr), int'(vecs[i].e_addr));
        end
        reset = 1'b0; load_new_note = 1'b0; beat = 1'b0; generate_next_sample = 1'b0;
        idle(2);

        // Note 49, 3 beats spaced 10 cycles apart.
        base_done = done_cnt;
        do_load(6'd49, 6'd3);
        for (int b = 0; b < 3; b++) begin
            idle(9);
            do_beat();
            if (b < 2) check("beats3 early done", int'(done_with_note), 0);
        end
        check("beats3 done pulse", int'(done_with_note), 1);
        check("beats3 active fell", int'(note_active), 0);
        idle(3);
        check("beats3 single done", done_cnt - base_done, 1);

        // 1000 sample strobes on A4.
        do_load(6'd49, 6'd3);
        idle(2);
        base_nsr = nsr_cnt;
        exp_phase = '0;
        for (int s = 0; s < 1000; s++) begin
            do_sample();
            exp_phase = exp_phase + 22'd38448;
        end
        check("1000 strobes count", nsr_cnt - base_nsr, 1000);
        check("1000 strobes addr", int'(sample_addr), 170);
        check("1000 strobes model", int'(sample_addr), int'(exp_phase[21:12]));

        // Pause mid-note; pre-empting the playing note issues no done.
        base_done = done_cnt;
        do_load(6'd49, 6'd4);
        idle(2);
        do_beat(); idle(3);
        do_beat(); idle(3);
        play_enable = 1'b0;
        held_addr = sample_addr;
        base_nsr = nsr_cnt;
        for (int i = 0; i < 5; i++) begin do_beat(); idle(2); end
        for (int i = 0; i < 20; i++) do_sample();
        check("pause nsr", nsr_cnt - base_nsr, 0);
        check("pause done", done_cnt - base_done, 0);
        check("pause active", int'(note_active), 1);
        check("pause addr held", int'(sample_addr), int'(held_addr));
        play_enable = 1'b1;
        idle(2);
        do_beat(); idle(3);
        check("resume early done", done_cnt - base_done, 0);
        do_beat();
        check("resume done pulse", int'(done_with_note), 1);
        check("resume active fell", int'(note_active), 0);

        // Rest: strobes still come, address pinned at 0.
        idle(3);
        do_load(6'd0, 6'd1);
        idle(2);
        base_nsr = nsr_cnt;
        for (int i = 0; i < 5; i++) begin
            do_sample();
            check($sformatf("rest addr %0d", i), int'(sample_addr), 0);
        end
        check("rest nsr", nsr_cnt - base_nsr, 5);
        do_beat();
        check("rest done", int'(done_with_note), 1);
        // Reader answers in the same cycle as done: load duration 0.
        do_load(6'd49, 6'd0);
        check("load with done active", int'(note_active), 1);
        idle(3);
        do_beat();
        check("dur0 done", int'(done_with_note), 1);
        check("dur0 active fell", int'(note_active), 0);

        // Load coincident with first beat: beat ignored, 5 more beats needed.
        idle(3);
        base_done = done_cnt;
        do_load(6'd49, 6'd2);
        idle(3);
        note_to_load = 6'd49; duration_to_load = 6'd5; load_new_note = 1'b1; beat = 1'b1;
        clk1();
        load_new_note = 1'b0; beat = 1'b0;
        for (int b = 0; b < 4; b++) begin idle(3); do_beat(); end
        check("preempt no early done", done_cnt - base_done, 0);
        check("preempt still active", int'(note_active), 1);
        idle(3);
        do_beat();
        check("preempt done pulse", int'(done_with_note), 1);
        idle(2);
        check("preempt single done", done_cnt - base_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
